// File: rtl/tick_ctrl_pkg.sv
// Shared types and default sizing for the per-tick neuron sweep controller.
package tick_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      STEP,
      ISSUE,
      WAIT,
      REARM
   } sweep_state_t;

   localparam int DEF_NUM_NEURONS = 256;
   localparam int DEF_IDX_WIDTH   = 8;
   localparam int DEF_OVR_WIDTH   = 8;

endpackage

// File: rtl/tick_sweep_controller_if.sv
// Bundle between the sweep controller (master) and its index counter / neuron datapath (slave).
interface tick_sweep_controller_if #(
   parameter int IDX_WIDTH = 8,
   parameter int OVR_WIDTH = 8
);

   logic                 tick;
   logic [IDX_WIDTH-1:0] idx;
   logic                 idx_wen;
   logic                 idx_rst;
   logic                 proc_valid;
   logic                 proc_ready;
   logic                 busy;
   logic                 done;
   logic                 overrun;
   logic [OVR_WIDTH-1:0] overrun_cnt;

   modport master (
      input  tick, idx, proc_ready,
      output idx_wen, idx_rst, proc_valid, busy, done, overrun, overrun_cnt
   );

   modport slave (
      output tick, idx, proc_ready,
      input  idx_wen, idx_rst, proc_valid, busy, done, overrun, overrun_cnt
   );

endinterface

// File: rtl/tick_sweep_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/tick_sweep_controller.sv
// Per-tick sweep sequencer: steps the negedge index counter and issues one process request per neuron.
// Optional dropped-tick counter enabled by defining TICK_OVERRUN_CNT_EN.
module tick_sweep_controller
   import tick_ctrl_pkg::*;
#(
   parameter int NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int IDX_WIDTH   = DEF_IDX_WIDTH,
   parameter int OVR_WIDTH   = DEF_OVR_WIDTH
) (
   input logic                      clk,
   input logic                      rst,
   tick_sweep_controller_if.master  bus
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

   sweep_state_t state;
   logic         rearm;
   logic         idx_wen_q;
   logic         proc_valid_q;
   logic         busy_q;
   logic         done_q;
   logic         overrun_q;
   logic         handshake;
   logic         overrun_set;

   assign handshake   = proc_valid_q && bus.proc_ready;
   assign overrun_set = bus.tick && (state != IDLE);

   // Outputs are registered one state ahead, so each appears in the cycle after its state;
   // the counter then steps on the negedge inside the ISSUE cycle and idx is stable in WAIT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         rearm        <= 1'b0;
         idx_wen_q    <= 1'b0;
         proc_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         idx_wen_q <= 1'b0;
         done_q    <= 1'b0;
         rearm     <= 1'b0;
         overrun_q <= overrun_set;
         case (state)
            IDLE: begin
               if (bus.tick) begin
                  busy_q <= 1'b1;
                  state  <= STEP;
               end
            end
            STEP: begin
               idx_wen_q <= 1'b1;
               state     <= ISSUE;
            end
            ISSUE, WAIT: begin
               if (handshake) begin
                  proc_valid_q <= 1'b0;
                  state        <= (bus.idx == LAST_IDX) ? REARM : STEP;
               end else if (state == ISSUE) begin
                  proc_valid_q <= 1'b1;
                  state        <= WAIT;
               end
            end
            REARM: begin
               rearm  <= 1'b1;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.idx_wen    = idx_wen_q;
   assign bus.proc_valid = proc_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.overrun    = overrun_q;
   // Counter reset is combinational so a controller reset also re-arms the counter at once.
   assign bus.idx_rst    = rst & ~rearm;

`ifdef TICK_OVERRUN_CNT_EN
   sat_counter #(
      .WIDTH (OVR_WIDTH)
   ) u_overrun_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (overrun_set),
      .count (bus.overrun_cnt)
   );
`else
   assign bus.overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_tick_sweep_controller.sv
// Scoreboard bench for tick_sweep_controller with a behavioural negedge index counter.
module tb_tick_sweep_controller;

   localparam int NUM_NEURONS = 4;
   localparam int IDX_WIDTH   = 8;
   localparam int OVR_WIDTH   = 2;
   localparam int NO_DONE     = -1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fails = 0;

   int exp_idx[$];
   int exp_done[$];
   int exp_ovr[$];

   tick_sweep_controller_if #(.IDX_WIDTH(IDX_WIDTH), .OVR_WIDTH(OVR_WIDTH)) bus ();

   tick_sweep_controller #(
      .NUM_NEURONS (NUM_NEURONS),
      .IDX_WIDTH   (IDX_WIDTH),
      .OVR_WIDTH   (OVR_WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [IDX_WIDTH-1:0] cnt_q;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream neuron-index counter: negedge, resets to all-ones.
   always_ff @(negedge clk) begin
      if (!bus.idx_rst)    cnt_q <= '1;
      else if (bus.idx_wen) cnt_q <= cnt_q + 1'b1;
   end
   assign bus.idx = cnt_q;

   task automatic check_output(input string name, input longint actual, input longint expected);
      n_tests++;
      if (actual != expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Called on a negedge; raises tick for one cycle and queues the expected response.
   task automatic apply_stimulus(input bit accept, input int n_idx, input int done_delay);
      bus.tick = 1'b1;
      if (accept) begin
         for (int i = 0; i < n_idx; i++) exp_idx.push_back(i);
         if (done_delay != NO_DONE) exp_done.push_back(cyc + done_delay);
      end else begin
         exp_ovr.push_back(cyc + 1);
      end
      @(negedge clk);
      bus.tick = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((exp_idx.size() != 0 || exp_done.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_output({name, "_pending"}, exp_idx.size() + exp_done.size(), 0);
      check_output({name, "_idx_rearmed"}, bus.idx, 8'hFF);
      check_output({name, "_busy_clear"}, bus.busy, 0);
   endtask

   // Monitor: samples just before each active edge and pops expectations on DUT events.
   initial begin
      int e;
      forever begin
         @(posedge clk);
         #8;
         check_output("wen_valid_exclusive", bus.idx_wen & bus.proc_valid, 0);
         if (rst && bus.proc_valid && bus.proc_ready) begin
            if (exp_idx.size() == 0) begin
               check_output("unexpected_handshake_idx", bus.idx, -1);
            end else begin
               e = exp_idx.pop_front();
               check_output("handshake_idx", bus.idx, e);
            end
         end
         if (bus.done) begin
            if (exp_done.size() == 0) begin
               check_output("unexpected_done", 1, 0);
            end else begin
               e = exp_done.pop_front();
               if (e >= 0) check_output("done_cycle", cyc, e);
            end
         end
         if (bus.overrun) begin
            if (exp_ovr.size() == 0) begin
               check_output("unexpected_overrun", 1, 0);
            end else begin
               e = exp_ovr.pop_front();
               check_output("overrun_cycle", cyc, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      bus.tick       = 1'b0;
      bus.proc_ready = 1'b1;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #2;
      check_output("reset_idx_rst_low", bus.idx_rst, 0);
      rst = 1'b1;
      @(posedge clk);
      #2;
      check_output("reset_busy", bus.busy, 0);
      check_output("reset_done", bus.done, 0);
      check_output("reset_proc_valid", bus.proc_valid, 0);
      check_output("reset_idx_wen", bus.idx_wen, 0);
      check_output("reset_overrun", bus.overrun, 0);
      check_output("reset_idx_rst", bus.idx_rst, 1);
      check_output("reset_idx", bus.idx, 8'hFF);
      check_output("reset_overrun_cnt", bus.overrun_cnt, 0);

      // Plain sweep, ready tied high: done 14 cycles after tick
      @(negedge clk);
      apply_stimulus(1'b1, NUM_NEURONS, 14);
      #2;
      check_output("busy_after_tick", bus.busy, 1);
      wait_idle("sweep_basic", 60);

      // Stall at idx 2 for five cycles
      wait_cycles(2);
      apply_stimulus(1'b1, NUM_NEURONS, 19);
      n = 0;
      while (!(bus.proc_valid && bus.idx == 8'd2) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_output("stall_reach_idx2", n < 40, 1);
      bus.proc_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #2;
         check_output("stall_proc_valid", bus.proc_valid, 1);
         check_output("stall_idx", bus.idx, 2);
         check_output("stall_idx_wen", bus.idx_wen, 0);
      end
      @(negedge clk);
      bus.proc_ready = 1'b1;
      wait_idle("sweep_stall", 60);

      // Two dropped ticks during a sweep
      wait_cycles(2);
      apply_stimulus(1'b1, NUM_NEURONS, 14);
      wait_cycles(2);
      apply_stimulus(1'b0, 0, NO_DONE);
      wait_cycles(3);
      apply_stimulus(1'b0, 0, NO_DONE);
      wait_idle("sweep_overrun2", 60);
`ifdef TICK_OVERRUN_CNT_EN
      check_output("overrun_cnt_two", bus.overrun_cnt, 2);
`endif

      // Three more dropped ticks, the last in the rearm cycle; 2-bit count saturates
      wait_cycles(2);
      apply_stimulus(1'b1, NUM_NEURONS, 14);
      wait_cycles(1);
      apply_stimulus(1'b0, 0, NO_DONE);
      wait_cycles(2);
      apply_stimulus(1'b0, 0, NO_DONE);
      wait_cycles(7);
      apply_stimulus(1'b0, 0, NO_DONE);
      wait_idle("sweep_overrun_rearm", 60);
`ifdef TICK_OVERRUN_CNT_EN
      check_output("overrun_cnt_saturated", bus.overrun_cnt, 3);
`endif

      // Reset while waiting on idx 1 aborts without done
      wait_cycles(2);
      apply_stimulus(1'b1, 1, NO_DONE);
      repeat (5) @(posedge clk);
      #2;
      check_output("abort_pre_valid", bus.proc_valid, 1);
      check_output("abort_pre_idx", bus.idx, 1);
      rst = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      check_output("abort_busy", bus.busy, 0);
      check_output("abort_proc_valid", bus.proc_valid, 0);
      check_output("abort_idx", bus.idx, 8'hFF);
      check_output("abort_overrun_cnt", bus.overrun_cnt, 0);
      @(negedge clk);
      apply_stimulus(1'b1, NUM_NEURONS, 14);
      wait_idle("sweep_after_abort", 60);

      // Back-to-back sweeps, second tick one cycle after done
      wait_cycles(2);
      apply_stimulus(1'b1, NUM_NEURONS, 14);
      wait_cycles(14);
      apply_stimulus(1'b1, NUM_NEURONS, 14);
      wait_idle("sweep_back_to_back", 80);

      wait_cycles(3);
      check_output("idx_queue_empty", exp_idx.size(), 0);
      check_output("done_queue_empty", exp_done.size(), 0);
      check_output("overrun_queue_empty", exp_ovr.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
